multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters; widths are fixed as listed below.
REQ-002 SHALL have ports, one per line:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- op  input  6  opcode field from the external instruction register.
- funct  input  6  funct field from the external instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- iord  output  1  address select: 0 = PC, 1 = ALU result.
- mem_write  output  1  store strobe; meaningful only with mem_req.
- ir_write  output  1  latch instruction register.
- pc_write  output  1  latch program counter.
- branch  output  1  PC update if ALU zero (beq).
- pc_src  output  2  00 = ALU result, 01 = branch-target register, 10 = jump target.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- reg_write  output  1  register-file write strobe.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALU-out, 1 = memory data.
- illegal  output  1  one-cycle pulse on an unsupported op/funct.
- state  output  4  current state encoding, for debug.

Function
REQ-003 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 SHALL go to FETCH.
REQ-004 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00, and ir_write=pc_write=mem_ready. It SHALL hold until mem_ready=1, then go to DECODE.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11, add. Next state by op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- else -> FETCH, with illegal=1 for that cycle.
REQ-006 R-type funct 100000/100010/100100/100101/101010 SHALL map to add/sub/and/or/slt. Any other funct in DECODE SHALL go to FETCH with illegal=1.
REQ-007 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, add. It SHALL go to MEMRD if op=100011, else to MEMWR.
REQ-008 MEMRD SHALL drive mem_req=1, iord=1. It SHALL hold until mem_ready=1, then go to MEMWB.
REQ-009 MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-010 MEMWR SHALL drive mem_req=1, iord=1, mem_write=1. It SHALL hold until mem_ready=1, then go to FETCH.
REQ-011 EXEC SHALL drive alu_src_a=1, alu_src_b=00, with alu_control decoded from funct, then go to ALUWB.
REQ-012 ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-013 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, then go to FETCH.
REQ-014 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, add, then go to ADDIWB.
REQ-015 ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-016 JUMP SHALL drive pc_write=1, pc_src=10, then go to FETCH.
REQ-017 Every strobe not listed for a state SHALL be 0; every unlisted select SHALL be 0; alu_control SHALL default to 010.
REQ-018 With zero wait states, latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-019 Each wait cycle with mem_ready=0 SHALL add exactly one cycle, with all outputs held stable.
REQ-020 op and funct SHALL be sampled only in DECODE and MEMADR. They are not required stable elsewhere.

Reset
REQ-021 rst_n=0 SHALL immediately force state=FETCH and all outputs to 0, including mem_req, regardless of clk.
REQ-022 After rst_n rises, the first rising clk edge SHALL see FETCH outputs per REQ-004.
REQ-023 Reset asserted mid-instruction SHALL abort it; no strobe SHALL be asserted while rst_n=0.

Verification
REQ-024 Reset, then lw (op=100011), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 only in cycle 5, with mem_to_reg=1.
REQ-025 sw with mem_ready low 3 cycles in MEMWR -> MEMWR held 4 cycles, mem_write=1 throughout; 7 cycles total.
REQ-026 R-type funct=100010 -> alu_control=110 in EXEC; reg_write=1, reg_dst=1 in ALUWB; 4 cycles.
REQ-027 beq -> branch=1, pc_src=01, alu_control=110 in cycle 3; j -> pc_write=1, pc_src=10 in cycle 3.
REQ-028 op=111111, then R-type funct=001000 -> illegal pulses 1 cycle in DECODE each time; state returns to FETCH; no reg_write or mem_write.
REQ-029 rst_n dropped in MEMRD with mem_req=1 -> mem_req=0 and state=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: a Moore state machine stepping
// through fetch, decode and per-class execute states. It drives datapath
// selects and strobes from the current state and waits on mem_ready for
// memory accesses.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     cur_state;
  state_t     next_state;
  logic [2:0] funct_alu;
  logic       funct_ok;
  logic       op_ok;
  logic [2:0] rtype_alu;

  // Translate the R-type funct field into an ALU operation and flag unsupported ones
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Recognise the supported opcodes
  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
      default:                                       op_ok = 1'b0;
    endcase
  end

  // Next-state selection; op and funct only matter in DECODE and MEMADR
  always_comb begin
    next_state = FETCH;
    case (cur_state)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = funct_ok ? EXEC : FETCH;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:  next_state = FETCH;
      MEMWR:  next_state = mem_ready ? FETCH : MEMWR;
      EXEC:   next_state = ALUWB;
      ALUWB:  next_state = FETCH;
      BRANCH: next_state = FETCH;
      ADDIEX: next_state = ADDIWB;
      ADDIWB: next_state = FETCH;
      JUMP:   next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // State register; the R-type ALU op is captured in DECODE so funct may change before EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      rtype_alu <= ALU_ADD;
    end else begin
      cur_state <= next_state;
      if (cur_state == DECODE) rtype_alu <= funct_alu;
    end
  end

  // Output decode from the current state, forced to all-zero while reset is held
  always_comb begin
    mem_req     = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      alu_control = ALU_ADD;
      case (cur_state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          illegal   = !op_ok || ((op == OP_RTYPE) && !funct_ok);
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = rtype_alu;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          branch      = 1'b1;
          pc_src      = 2'b01;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDIWB: begin
          reg_write = 1'b1;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: begin
          alu_control = ALU_ADD;
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instructions followed by
// randomized instruction streams with random memory wait states, compared
// each cycle against a per-instruction step-list model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state;

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } outs_t;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Expected outputs for a named step of an instruction
  function automatic outs_t expected_for(input int st, input bit rdy,
                                         input logic [2:0] alu, input bit ill);
    outs_t e;
    e = '0;
    e.st = 4'(st);
    e.alu_control = 3'b010;
    case (st)
      0:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      1:  begin e.alu_src_b = 2'b11; e.illegal = ill; end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_req = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      5:  begin e.mem_req = 1; e.iord = 1; e.mem_write = 1; end
      6:  begin e.alu_src_a = 1; e.alu_control = alu; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; end
      8:  begin e.alu_src_a = 1; e.alu_control = 3'b110; e.branch = 1; e.pc_src = 2'b01; end
      9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      10: begin e.reg_write = 1; end
      11: begin e.pc_write = 1; e.pc_src = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic outs_t observed();
    outs_t a;
    a = {state, mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src,
         alu_src_a, alu_src_b, alu_control, reg_write, reg_dst, mem_to_reg, illegal};
    return a;
  endfunction

  task automatic checkOutput(input outs_t exp_v, input string tag);
    outs_t obs;
    obs = observed();
    vectors_applied++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, advance
  task automatic applyStimulus(input int st, input bit rdy, input logic [5:0] o,
                               input logic [5:0] f, input logic [2:0] alu,
                               input bit ill, input string tag);
    mem_ready = rdy;
    op        = o;
    funct     = f;
    #3;
    checkOutput(expected_for(st, rdy, alu, ill), tag);
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction through its expected step list
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int fetch_waits, input int mem_waits, input string tag);
    logic [2:0] ralu;
    bit         fok;
    bit         ill;
    fok  = 1'b1;
    ralu = 3'b010;
    case (f)
      6'b100000: ralu = 3'b010;
      6'b100010: ralu = 3'b110;
      6'b100100: ralu = 3'b000;
      6'b100101: ralu = 3'b001;
      6'b101010: ralu = 3'b111;
      default:   fok = 1'b0;
    endcase
    ill = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
            o == 6'b000100 || o == 6'b001000 || o == 6'b000010) ||
          (o == 6'b000000 && !fok);
    for (int i = 0; i < fetch_waits; i++)
      applyStimulus(0, 0, 6'($urandom), 6'($urandom), ralu, 0, {tag, "_fetchwait"});
    applyStimulus(0, 1, 6'($urandom), 6'($urandom), ralu, 0, {tag, "_fetch"});
    applyStimulus(1, 1'($urandom), o, f, ralu, ill, {tag, "_decode"});
    if (ill) return;
    case (o)
      6'b100011: begin
        applyStimulus(2, 1'($urandom), o, f, ralu, 0, {tag, "_memadr"});
        for (int i = 0; i < mem_waits; i++)
          applyStimulus(3, 0, 6'($urandom), 6'($urandom), ralu, 0, {tag, "_memrdwait"});
        applyStimulus(3, 1, 6'($urandom), 6'($urandom), ralu, 0, {tag, "_memrd"});
        applyStimulus(4, 1'($urandom), 6'($urandom), 6'($urandom), ralu, 0, {tag, "_memwb"});
      end
      6'b101011: begin
        applyStimulus(2, 1'($urandom), o, f, ralu, 0, {tag, "_memadr"});
        for (int i = 0; i < mem_waits; i++)
          applyStimulus(5, 0, 6'($urandom), 6'($urandom), ralu, 0, {tag, "_memwrwait"});
        applyStimulus(5, 1, 6'($urandom), 6'($urandom), ralu, 0, {tag, "_memwr"});
      end
      6'b000000: begin
        applyStimulus(6, 1'($urandom), 6'($urandom), 6'($urandom), ralu, 0, {tag, "_exec"});
        applyStimulus(7, 1'($urandom), 6'($urandom), 6'($urandom), ralu, 0, {tag, "_aluwb"});
      end
      6'b000100:
        applyStimulus(8, 1'($urandom), 6'($urandom), 6'($urandom), ralu, 0, {tag, "_branch"});
      6'b001000: begin
        applyStimulus(9, 1'($urandom), 6'($urandom), 6'($urandom), ralu, 0, {tag, "_addiex"});
        applyStimulus(10, 1'($urandom), 6'($urandom), 6'($urandom), ralu, 0, {tag, "_addiwb"});
      end
      default:
        applyStimulus(11, 1'($urandom), 6'($urandom), 6'($urandom), ralu, 0, {tag, "_jump"});
    endcase
  endtask

  // Directed sequence, reset abort, then a randomized instruction stream
  initial begin
    logic [5:0] valid_funct [5];
    logic [5:0] rop;
    logic [5:0] rfn;
    valid_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    rst_n     = 1'b0;
    mem_ready = 1'b1;
    op        = 6'b100011;
    funct     = 6'b100000;
    #12;
    checkOutput('0, "reset_hold");
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    #1;
    checkOutput(expected_for(0, 0, 3'b010, 0), "reset_release");
    @(posedge clk);
    #1;

    run_instr(6'b100011, 6'b000000, 0, 0, "lw");
    run_instr(6'b101011, 6'b000000, 0, 3, "sw_wait3");
    run_instr(6'b000000, 6'b100010, 0, 0, "rtype_sub");
    run_instr(6'b000000, 6'b101010, 2, 0, "rtype_slt");
    run_instr(6'b000100, 6'b000000, 0, 0, "beq");
    run_instr(6'b000010, 6'b000000, 0, 0, "j");
    run_instr(6'b001000, 6'b000000, 1, 0, "addi");
    run_instr(6'b111111, 6'b000000, 0, 0, "illegal_op");
    run_instr(6'b000000, 6'b001000, 0, 0, "illegal_funct");
    run_instr(6'b100011, 6'b000000, 2, 2, "lw_waits");

    // Reset dropped mid-cycle while MEMRD is requesting memory
    applyStimulus(0, 1, 6'b000000, 6'b000000, 3'b010, 0, "abort_fetch");
    applyStimulus(1, 1, 6'b100011, 6'b000000, 3'b010, 0, "abort_decode");
    applyStimulus(2, 1, 6'b100011, 6'b000000, 3'b010, 0, "abort_memadr");
    mem_ready = 1'b0;
    #2;
    checkOutput(expected_for(3, 0, 3'b010, 0), "abort_memrd");
    rst_n = 1'b0;
    #1;
    checkOutput('0, "abort_async");
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    checkOutput('0, "abort_hold");
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    #1;
    checkOutput(expected_for(0, 0, 3'b010, 0), "abort_release");
    @(posedge clk);
    #1;

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0:       rop = 6'b100011;
        1:       rop = 6'b101011;
        2, 3:    rop = 6'b000000;
        4:       rop = 6'b000100;
        5:       rop = 6'b001000;
        6:       rop = 6'b000010;
        default: rop = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) rfn = 6'($urandom);
      else rfn = valid_funct[$urandom_range(0, 4)];
      run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
